// File: rtl/output_drain_ctrl.sv
// Drain controller for the systolic array's output memory: captures a result
// tile on array_done, then streams it word by word over valid/ready.
module output_drain_ctrl #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              array_done,
  output logic              mem_en,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              tile_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    FETCH   = 3'd2,
    LATCH   = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  idx, idx_next;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               done_q;
  logic               overrun_q;
  logic               is_last;

  assign is_last = (idx == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (array_done) begin
          state_next = CAPTURE;
          idx_next   = '0;
        end
      end
      CAPTURE: state_next = FETCH;
      FETCH:   state_next = LATCH;
      LATCH:   state_next = SEND;
      SEND: begin
        if (out_ready) begin
          if (is_last) begin
            state_next = IDLE;
          end else begin
            state_next = FETCH;
            idx_next   = idx + ADDR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address is loaded on entry to FETCH so it holds its last value afterwards;
  // memory read data is valid during LATCH and is registered at its end.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      idx    <= idx_next;
      done_q <= (state == SEND) && out_ready && is_last;
      if (state_next == FETCH) addr_q <= idx_next;
      if (state == LATCH)      data_q <= mem_data;
      if (array_done && (state != IDLE)) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    mem_en    = (state == CAPTURE);
    mem_read  = (state == FETCH);
    mem_addr  = addr_q;
    out_valid = (state == SEND);
    out_last  = (state == SEND) && is_last;
    out_data  = data_q;
    busy      = (state != IDLE);
    tile_done = done_q;
    overrun   = overrun_q;
  end

endmodule
